sipo_reg: RTL and testbench

Serial-in, parallel-out deserializer: the receive-side counterpart of the team's parallel-load shift register. Samples one serial bit per `shift_i` strobe, assembles `WIDTH`-bit words, and presents each completed word on a valid/ready output port. Sits between a serial link front end and the word-oriented datapath, with a one-word holding register and sticky overrun detection.

---
 rtl/sipo_reg.sv | 104 ++++++++++
 tb/tb_sipo_reg.sv | 204 ++++++++++++++++++++
 2 files changed

// File: rtl/sipo_reg.sv
// Serial-in, parallel-out deserializer with a one-word valid/ready holding
// register and sticky overrun detection for words that arrive while it is full.
module sipo_reg #(
  parameter int WIDTH     = 8,
  parameter int MSB_FIRST = 1
) (
  input  logic             clk_i,
  input  logic             rst_ni,
  input  logic             din_i,
  input  logic             shift_i,
  input  logic             clear_i,
  output logic [WIDTH-1:0] dout_o,
  output logic             valid_o,
  input  logic             ready_i,
  output logic             overrun_o
);

  localparam int CW = (WIDTH > 1) ? $clog2(WIDTH) : 1;
  localparam logic [CW-1:0] LAST = CW'(WIDTH - 1);

  logic [WIDTH-1:0] sr;
  logic [CW-1:0]    cnt;
  logic [WIDTH-1:0] hold;
  logic             valid;
  logic             ovr;

  logic [WIDTH-1:0] sr_next;
  logic             accept;
  logic             complete;
  logic             xfer;
  logic             load;
  logic             drop;

  // NOTE: every signal driven here gets a default first, so no path leaves it
  // unassigned and no latch is inferred.
  always_comb begin
    sr_next  = sr;
    accept   = shift_i && !clear_i;
    complete = accept && (cnt == LAST);
    xfer     = valid && ready_i;
    // A completed word may take the holding slot if it is empty or being
    // drained on this very edge; otherwise it is lost.
    load     = complete && (!valid || ready_i);
    drop     = complete && valid && !ready_i;
    if (MSB_FIRST != 0) begin
      sr_next = {sr[WIDTH-2:0], din_i};
    end else begin
      sr_next = {din_i, sr[WIDTH-1:1]};
    end
  end

  // NOTE: sequential state uses non-blocking assignments so every register
  // samples the pre-edge values regardless of statement order.
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      sr  <= '0;
      cnt <= '0;
    end else if (clear_i) begin
      sr  <= '0;
      cnt <= '0;
    end else if (shift_i) begin
      if (cnt == LAST) begin
        sr  <= '0;
        cnt <= '0;
      end else begin
        sr  <= sr_next;
        cnt <= cnt + CW'(1);
      end
    end
  end

  // NOTE: the holding register is a plain register, not a memory, so it is
  // reset with the rest of the state to give a defined dout_o after reset.
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      hold  <= '0;
      valid <= 1'b0;
    end else begin
      if (load) begin
        hold <= sr_next;
      end
      if (load) begin
        valid <= 1'b1;
      end else if (xfer) begin
        valid <= 1'b0;
      end
    end
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      ovr <= 1'b0;
    end else if (clear_i) begin
      ovr <= 1'b0;
    end else if (drop) begin
      ovr <= 1'b1;
    end
  end

  assign dout_o    = hold;
  assign valid_o   = valid;
  assign overrun_o = ovr;

endmodule

// File: tb/tb_sipo_reg.sv
// Self-checking bench for sipo_reg: one MSB-first and one LSB-first instance
// share stimulus and are compared every cycle against a word-level model.
module tb_sipo_reg;

  localparam int W = 8;

  logic         clk = 1'b0;
  logic         rst_n = 1'b0;
  logic         din = 1'b0;
  logic         shift = 1'b0;
  logic         clear = 1'b0;
  logic         ready = 1'b0;
  logic [W-1:0] dout_m, dout_l;
  logic         valid_m, valid_l, ovr_m, ovr_l;

  int checks = 0;
  int failures = 0;

  // Model state, index 1 = MSB-first instance, index 0 = LSB-first instance.
  int           m_cnt   [2];
  int unsigned  m_acc   [2];
  logic [W-1:0] m_hold  [2];
  logic         m_valid [2];
  logic         m_ovr   [2];

  always #5 clk = ~clk;

  sipo_reg #(.WIDTH(W), .MSB_FIRST(1)) dut_m (
    .clk_i(clk), .rst_ni(rst_n), .din_i(din), .shift_i(shift), .clear_i(clear),
    .dout_o(dout_m), .valid_o(valid_m), .ready_i(ready), .overrun_o(ovr_m)
  );

  sipo_reg #(.WIDTH(W), .MSB_FIRST(0)) dut_l (
    .clk_i(clk), .rst_ni(rst_n), .din_i(din), .shift_i(shift), .clear_i(clear),
    .dout_o(dout_l), .valid_o(valid_l), .ready_i(ready), .overrun_o(ovr_l)
  );

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s: observed=0x%0h expected=0x%0h", tag, obs, exp);
    end
  endtask

  task automatic model_reset();
    for (int k = 0; k < 2; k++) begin
      m_cnt[k] = 0; m_acc[k] = 0; m_hold[k] = '0; m_valid[k] = 1'b0; m_ovr[k] = 1'b0;
    end
  endtask

  // Word-level behaviour: bits are counted into an integer; on the W-th bit the
  // integer becomes the word, offered to the single-entry output slot.
  task automatic model_step();
    for (int k = 0; k < 2; k++) begin
      bit xfer;
      bit nvalid;
      xfer   = m_valid[k] && ready;
      nvalid = xfer ? 1'b0 : m_valid[k];
      if (clear) begin
        m_cnt[k] = 0; m_acc[k] = 0; m_ovr[k] = 1'b0;
      end else if (shift) begin
        if (k == 1) m_acc[k] = m_acc[k] * 2 + int'(din);
        else        m_acc[k] = m_acc[k] + (int'(din) << m_cnt[k]);
        m_cnt[k]++;
        if (m_cnt[k] == W) begin
          if (!m_valid[k] || ready) begin
            m_hold[k] = m_acc[k][W-1:0];
            nvalid    = 1'b1;
          end else begin
            m_ovr[k] = 1'b1;
          end
          m_cnt[k] = 0; m_acc[k] = 0;
        end
      end
      m_valid[k] = nvalid;
    end
  endtask

  task automatic compare_model(input string tag);
    check({tag, ".dout_m"},  dout_m,  m_hold[1]);
    check({tag, ".valid_m"}, valid_m, m_valid[1]);
    check({tag, ".ovr_m"},   ovr_m,   m_ovr[1]);
    check({tag, ".dout_l"},  dout_l,  m_hold[0]);
    check({tag, ".valid_l"}, valid_l, m_valid[0]);
    check({tag, ".ovr_l"},   ovr_l,   m_ovr[0]);
  endtask

  task automatic check_zero(input string tag);
    check({tag, ".dout_m"}, dout_m, '0);
    check({tag, ".valid_m"}, valid_m, 1'b0);
    check({tag, ".ovr_m"}, ovr_m, 1'b0);
    check({tag, ".dout_l"}, dout_l, '0);
    check({tag, ".valid_l"}, valid_l, 1'b0);
    check({tag, ".ovr_l"}, ovr_l, 1'b0);
  endtask

  // One clock: drive on the falling edge, step the model on the rising edge,
  // compare just after it.
  task automatic cycle(input logic d, input logic s, input logic c, input logic r,
                       input string tag);
    @(negedge clk);
    din = d; shift = s; clear = c; ready = r;
    @(posedge clk);
    model_step();
    #1;
    compare_model(tag);
  endtask

  // Sends a word MSB of w first; ready is r_last on the final strobe.
  task automatic send_word(input logic [W-1:0] w, input logic r_other,
                           input logic r_last, input string tag);
    logic [W-1:0] v;
    v = w;
    for (int i = W - 1; i >= 0; i--) begin
      cycle(v[i], 1'b1, 1'b0, (i == 0) ? r_last : r_other, tag);
    end
  endtask

  initial begin
    model_reset();

    // Reset held with random inputs toggling.
    rst_n = 1'b0;
    for (int i = 0; i < 6; i++) begin
      @(negedge clk);
      din = 1'($urandom); shift = 1'($urandom); ready = 1'($urandom);
      @(posedge clk); #1;
      check_zero("reset_hold");
    end
    @(negedge clk);
    din = 1'b0; shift = 1'b0; clear = 1'b0; ready = 1'b0;
    #2 rst_n = 1'b1;
    #1 check_zero("reset_release");

    // 0xA5 with ready high: valid for exactly one cycle.
    send_word(8'hA5, 1'b1, 1'b1, "a5");
    check("a5.dout_m", dout_m, 8'hA5);
    check("a5.dout_l", dout_l, 8'hA5);
    check("a5.valid_m", valid_m, 1'b1);
    cycle(1'b0, 1'b0, 1'b0, 1'b1, "a5_drain");
    check("a5.valid_after", valid_m, 1'b0);

    // Single leading one: bit order distinguishes the two instances.
    send_word(8'h80, 1'b1, 1'b1, "first1");
    check("first1.dout_m", dout_m, 8'h80);
    check("first1.dout_l", dout_l, 8'h01);
    cycle(1'b0, 1'b0, 1'b0, 1'b1, "first1_drain");

    // Backpressure: second word dropped, 0x3C held, overrun sticky.
    send_word(8'h3C, 1'b0, 1'b0, "bp1");
    send_word(8'hFF, 1'b0, 1'b0, "bp2");
    check("bp.dout_m", dout_m, 8'h3C);
    check("bp.dout_l", dout_l, 8'h3C);
    check("bp.ovr_m", ovr_m, 1'b1);
    cycle(1'b0, 1'b0, 1'b0, 1'b1, "bp_xfer");
    check("bp.valid_after", valid_m, 1'b0);
    check("bp.ovr_sticky", ovr_m, 1'b1);
    cycle(1'b0, 1'b0, 1'b1, 1'b0, "bp_clear");
    check("bp.ovr_cleared", ovr_m, 1'b0);

    // Same-cycle drain on the completion edge of the second word.
    send_word(8'h3C, 1'b0, 1'b0, "drain1");
    send_word(8'h55, 1'b0, 1'b1, "drain2");
    check("drain.dout_m", dout_m, 8'h55);
    check("drain.dout_l", dout_l, 8'hAA);
    check("drain.valid_m", valid_m, 1'b1);
    check("drain.ovr_m", ovr_m, 1'b0);
    cycle(1'b0, 1'b0, 1'b0, 1'b1, "drain_xfer");

    // Resync: partial word discarded by clear concurrent with a strobe.
    for (int i = 0; i < 3; i++) cycle(1'b1, 1'b1, 1'b0, 1'b1, "resync_partial");
    cycle(1'b1, 1'b1, 1'b1, 1'b1, "resync_clear");
    send_word(8'hC3, 1'b1, 1'b1, "resync");
    check("resync.dout_m", dout_m, 8'hC3);
    check("resync.dout_l", dout_l, 8'hC3);
    cycle(1'b0, 1'b0, 1'b0, 1'b1, "resync_drain");

    // Reset mid-word with a pending word: everything lost, next word clean.
    send_word(8'h3C, 1'b0, 1'b0, "mid_pend");
    for (int i = 0; i < 5; i++) cycle(1'b1, 1'b1, 1'b0, 1'b0, "mid_partial");
    #2;
    din = 1'b0; shift = 1'b0; clear = 1'b0; ready = 1'b0;
    rst_n = 1'b0;
    #1 check_zero("mid_reset_async");
    model_reset();
    @(negedge clk);
    #1 rst_n = 1'b1;
    #1 check_zero("mid_reset_release");
    send_word(8'h5A, 1'b1, 1'b1, "post_reset");
    check("post_reset.dout_m", dout_m, 8'h5A);
    check("post_reset.dout_l", dout_l, 8'h5A);

    // Randomized traffic against the model.
    for (int i = 0; i < 3000; i++) begin
      cycle(1'($urandom), ($urandom_range(3, 0) != 0), ($urandom_range(47, 0) == 0),
            1'($urandom), "random");
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
